// File: rtl/upcoin_pkg.sv
// Shared constants and types for the upcoin nonce scheduler: SHA-256 IV,
// block-1 padding, header geometry and the scheduler state encoding.
package upcoin_pkg;

  localparam int HEADER_BITS = 640;
  localparam int BLK_BITS    = 512;
  localparam int HASH_BITS   = 256;

  localparam logic [HASH_BITS-1:0] SHA256_IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  // Second block tail: terminating 1 bit, zero fill, 64-bit message length in bits.
  localparam logic [383:0] BLK1_PAD = {1'b1, 319'b0, 64'd640};

  typedef enum logic [2:0] {
    IDLE,
    START0,
    WAIT0,
    START1,
    WAIT1,
    CHECK,
    DONE
  } sched_state_t;

  function automatic logic digest_below(input logic [HASH_BITS-1:0] i_digest,
                                        input logic [HASH_BITS-1:0] i_target);
    return (i_digest < i_target);
  endfunction

endpackage

// File: rtl/upcoin_block_builder.sv
// Combinational builder of the two padded SHA-256 blocks for one nonce.
// The header's own nonce field is not an input; the supplied nonce replaces it.
module upcoin_block_builder
  import upcoin_pkg::*;
#(
  parameter int NONCE_W = 32
) (
  input  logic [HEADER_BITS-1:NONCE_W] i_header_hi,
  input  logic [NONCE_W-1:0]           i_nonce,
  output logic [BLK_BITS-1:0]          o_blk0,
  output logic [BLK_BITS-1:0]          o_blk1
);

  assign o_blk0 = i_header_hi[HEADER_BITS-1:128];
  assign o_blk1 = {i_header_hi[127:NONCE_W], i_nonce, BLK1_PAD};

endmodule

// File: rtl/upcoin_nonce_scheduler.sv
// Nonce search sequencer around an external SHA-256 compression core.
// Optional build macro UPCOIN_MIDSTATE_EN: compress block 0 once per search.
module upcoin_nonce_scheduler
  import upcoin_pkg::*;
#(
  parameter int NONCE_W     = 32,
  parameter int TIMEOUT_CYC = 127
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [HEADER_BITS-1:0] header,
  input  logic [HASH_BITS-1:0]   target,
  input  logic [NONCE_W-1:0]     nonce_start,
  input  logic [NONCE_W-1:0]     nonce_end,
  output logic                   core_start,
  output logic [BLK_BITS-1:0]    core_block,
  output logic [HASH_BITS-1:0]   core_iv,
  input  logic                   core_done,
  input  logic [HASH_BITS-1:0]   core_hash,
  output logic                   busy,
  output logic                   found,
  output logic                   exhausted,
  output logic                   error,
  output logic [NONCE_W-1:0]     nonce_out,
  output logic [HASH_BITS-1:0]   hash_out
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  sched_state_t                 r_state;
  sched_state_t                 w_state_nxt;
  logic [NONCE_W-1:0]           r_nonce;
  logic [NONCE_W-1:0]           r_nonce_end;
  logic [TMO_W-1:0]             r_tmo;
  logic                         r_found;
  logic                         r_exh;
  logic                         r_err;
  logic [NONCE_W-1:0]           r_nonce_out;
  logic [HASH_BITS-1:0]         r_hash_out;
  logic [HEADER_BITS-1:NONCE_W] r_header;
  logic [HASH_BITS-1:0]         r_target;
  logic [HASH_BITS-1:0]         r_chain;
  logic [HASH_BITS-1:0]         r_digest;
  logic [BLK_BITS-1:0]          w_blk0;
  logic [BLK_BITS-1:0]          w_blk1;
  logic                         w_tmo_hit;
  logic                         w_win;
  logic                         w_last;
  logic                         w_accept;
  logic                         w_unused;
`ifdef UPCOIN_MIDSTATE_EN
  logic                         r_mid_vld;
`endif

  // The incoming header's nonce field is always overwritten by the search nonce.
  assign w_unused  = ^header[NONCE_W-1:0];

  assign w_accept  = (r_state == IDLE) && start && !abort;
  assign w_tmo_hit = (r_tmo == TMO_W'(TIMEOUT_CYC - 1));
  assign w_win     = digest_below(r_digest, r_target);
  assign w_last    = (r_nonce == r_nonce_end);

  upcoin_block_builder #(
    .NONCE_W (NONCE_W)
  ) u_builder (
    .i_header_hi (r_header),
    .i_nonce     (r_nonce),
    .o_blk0      (w_blk0),
    .o_blk1      (w_blk1)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:   if (start) w_state_nxt = START0;
      START0: w_state_nxt = WAIT0;
      WAIT0: begin
        if (core_done)      w_state_nxt = START1;
        else if (w_tmo_hit) w_state_nxt = DONE;
      end
      START1: w_state_nxt = WAIT1;
      WAIT1: begin
        if (core_done)      w_state_nxt = CHECK;
        else if (w_tmo_hit) w_state_nxt = DONE;
      end
      CHECK: begin
        if (w_win || w_last) begin
          w_state_nxt = DONE;
        end else begin
`ifdef UPCOIN_MIDSTATE_EN
          w_state_nxt = r_mid_vld ? START1 : START0;
`else
          w_state_nxt = START0;
`endif
        end
      end
      DONE:    if (!start) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    // Abort outranks every other transition, including a same-cycle core_done.
    if (abort) w_state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_nonce     <= '0;
      r_tmo       <= '0;
      r_found     <= 1'b0;
      r_exh       <= 1'b0;
      r_err       <= 1'b0;
      r_nonce_out <= '0;
      r_hash_out  <= '0;
`ifdef UPCOIN_MIDSTATE_EN
      r_mid_vld   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      if (abort) begin
`ifdef UPCOIN_MIDSTATE_EN
        r_mid_vld <= 1'b0;
`endif
      end else begin
        case (r_state)
          IDLE: begin
            if (start) begin
              r_found   <= 1'b0;
              r_exh     <= 1'b0;
              r_err     <= 1'b0;
              r_nonce   <= nonce_start;
`ifdef UPCOIN_MIDSTATE_EN
              r_mid_vld <= 1'b0;
`endif
            end
          end
          START0, START1: r_tmo <= TMO_W'(1);
          WAIT0, WAIT1: begin
            r_tmo <= r_tmo + 1'b1;
            if (!core_done && w_tmo_hit) r_err <= 1'b1;
`ifdef UPCOIN_MIDSTATE_EN
            if ((r_state == WAIT0) && core_done) r_mid_vld <= 1'b1;
`endif
          end
          CHECK: begin
            r_nonce_out <= r_nonce;
            r_hash_out  <= r_digest;
            if (w_win)       r_found <= 1'b1;
            else if (w_last) r_exh   <= 1'b1;
            else             r_nonce <= r_nonce + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Captured search inputs and chaining values: no reset needed, always written before use.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_header    <= header[HEADER_BITS-1:NONCE_W];
      r_target    <= target;
      r_nonce_end <= nonce_end;
    end
    if ((r_state == WAIT0) && core_done && !abort) r_chain  <= core_hash;
    if ((r_state == WAIT1) && core_done && !abort) r_digest <= core_hash;
  end

  always_comb begin
    core_block = '0;
    core_iv    = '0;
    if (r_state == START0) begin
      core_block = w_blk0;
      core_iv    = SHA256_IV;
    end else if (r_state == START1) begin
      core_block = w_blk1;
      core_iv    = r_chain;
    end
  end

  assign core_start = (r_state == START0) || (r_state == START1);
  assign busy       = (r_state != IDLE) && (r_state != DONE);
  assign found      = r_found;
  assign exhausted  = r_exh;
  assign error      = r_err;
  assign nonce_out  = r_nonce_out;
  assign hash_out   = r_hash_out;

endmodule

// File: tb/tb_upcoin_nonce_scheduler.sv
// Scoreboard bench for upcoin_nonce_scheduler with a behavioural compression core.
// Expected core requests and final results are queued at stimulus time and checked by monitors.
module tb_upcoin_nonce_scheduler;

  localparam int TMO = 127;
  localparam logic [255:0] IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [639:0] GENESIS =
    640'h01000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_3ba3edfd_7a7b12b2_7ac72c3e_67768f61_7fc81bc3_888a5132_3a9fb8aa_4b1e5e4a_29ab5f49_ffff001d_1dac2b7c;
`ifdef UPCOIN_MIDSTATE_EN
  localparam bit MID = 1'b1;
`else
  localparam bit MID = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [639:0] header = '0;
  logic [255:0] target = '0;
  logic [31:0]  nonce_start = '0;
  logic [31:0]  nonce_end = '0;
  logic         core_start;
  logic [511:0] core_block;
  logic [255:0] core_iv;
  logic         core_done = 1'b0;
  logic [255:0] core_hash = '0;
  logic         busy, found, exhausted, error;
  logic [31:0]  nonce_out;
  logic [255:0] hash_out;

  upcoin_nonce_scheduler #(.NONCE_W(32), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .header(header), .target(target), .nonce_start(nonce_start), .nonce_end(nonce_end),
    .core_start(core_start), .core_block(core_block), .core_iv(core_iv),
    .core_done(core_done), .core_hash(core_hash),
    .busy(busy), .found(found), .exhausted(exhausted), .error(error),
    .nonce_out(nonce_out), .hash_out(hash_out)
  );

  always #5 clk = ~clk;

  typedef struct { logic [511:0] blk; logic [255:0] iv; } core_t;
  typedef struct { bit f; bit e; bit er; bit chk; logic [31:0] n; logic [255:0] h; } res_t;

  core_t exp_core[$];
  res_t  exp_res[$];
  int    checks = 0;
  int    errors = 0;
  int    n_starts = 0;
  logic [255:0] hmask = '1;
  bit    mute = 1'b0;
  bit    abort_arm = 1'b0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, exp);
    end
  endtask

  // Stand-in compression function; any fixed mixing of block and IV serves the scheduler.
  function automatic logic [255:0] cf(input logic [511:0] b, input logic [255:0] v);
    return ((b[511:256] ^ b[255:0]) + v) & hmask;
  endfunction

  function automatic logic [511:0] mk_b1(input logic [639:0] h, input logic [31:0] n);
    return {h[127:32], n, 1'b1, 319'b0, 64'd640};
  endfunction

  task automatic push_core(input logic [511:0] b, input logic [255:0] v);
    core_t c;
    c.blk = b;
    c.iv  = v;
    exp_core.push_back(c);
  endtask

  task automatic push_run(input logic [639:0] h, input logic [255:0] t,
                          input logic [31:0] ns, input logic [31:0] ne);
    logic [31:0]  n;
    logic [511:0] b0, b1;
    logic [255:0] mid, d;
    res_t r;
    n   = ns;
    b0  = h[639:128];
    mid = cf(b0, IV);
    for (int i = 0; i < 64; i++) begin
      if (!MID || i == 0) push_core(b0, IV);
      b1 = mk_b1(h, n);
      push_core(b1, mid);
      d = cf(b1, mid);
      r.f = 1'b0; r.e = 1'b0; r.er = 1'b0; r.chk = 1'b1; r.n = n; r.h = d;
      if (d < t) begin
        r.f = 1'b1;
        exp_res.push_back(r);
        break;
      end
      if (n == ne) begin
        r.e = 1'b1;
        exp_res.push_back(r);
        break;
      end
      n = n + 32'd1;
    end
  endtask

  task automatic issue(input logic [639:0] h, input logic [255:0] t,
                       input logic [31:0] ns, input logic [31:0] ne);
    @(negedge clk);
    header = h; target = t; nonce_start = ns; nonce_end = ne; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    header = ~h; target = ~t; nonce_start = ~ns; nonce_end = ~ne;
  endtask

  task automatic wait_term(input string name);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (found || exhausted || error) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk({name, "_terminated"}, hit, 1'b1);
    @(negedge clk);
    chk({name, "_queue_drained"}, exp_core.size(), 0);
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_core_start"}, core_start, 1'b0);
    chk({name, "_core_block"}, core_block, '0);
    chk({name, "_core_iv"}, core_iv, '0);
    chk({name, "_busy"}, busy, 1'b0);
    chk({name, "_found"}, found, 1'b0);
    chk({name, "_exhausted"}, exhausted, 1'b0);
    chk({name, "_error"}, error, 1'b0);
    chk({name, "_nonce_out"}, nonce_out, '0);
    chk({name, "_hash_out"}, hash_out, '0);
  endtask

  // Core request monitor.
  always @(negedge clk) begin
    core_t c;
    if (!reset && core_start) begin
      n_starts++;
      if (exp_core.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL core_start_unexpected block %h iv %h", core_block, core_iv);
      end else begin
        c = exp_core.pop_front();
        chk("core_block", core_block, c.blk);
        chk("core_iv", core_iv, c.iv);
      end
    end
  end

  // Result monitor: fires when a terminal flag appears.
  logic prev_flag = 1'b0;
  always @(negedge clk) begin
    res_t r;
    logic cur;
    cur = found | exhausted | error;
    if (cur && !prev_flag) begin
      if (exp_res.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL result_unexpected found %b exhausted %b error %b", found, exhausted, error);
      end else begin
        r = exp_res.pop_front();
        chk("res_found", found, r.f);
        chk("res_exhausted", exhausted, r.e);
        chk("res_error", error, r.er);
        chk("res_busy", busy, 1'b0);
        if (r.chk) begin
          chk("res_nonce_out", nonce_out, r.n);
          chk("res_hash_out", hash_out, r.h);
        end
      end
    end
    prev_flag = cur;
  end

  // Behavioural core: answers three cycles after each request unless muted.
  int           mdl_cnt = 0;
  bit           mdl_pend = 1'b0;
  bit           mdl_b1 = 1'b0;
  logic [255:0] mdl_h = '0;
  always @(negedge clk) begin
    core_done = 1'b0;
    abort     = 1'b0;
    if (mdl_pend) begin
      if (mdl_cnt == 0) begin
        core_done = 1'b1;
        core_hash = mdl_h;
        mdl_pend  = 1'b0;
        if (abort_arm && mdl_b1) abort = 1'b1;
      end else begin
        mdl_cnt--;
      end
    end
    if (core_start && !reset && !mute) begin
      mdl_pend = 1'b1;
      mdl_cnt  = 2;
      mdl_h    = cf(core_block, core_iv);
      mdl_b1   = (core_iv != IV);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] d;
    logic [639:0] h2;
    int s0, cyc;
    bit hit;

    repeat (3) @(negedge clk);
    chk_zero("reset_hold");
    reset = 1'b0;
    @(negedge clk);
    chk_zero("reset_release");

    // Genesis header, single nonce, digest forced below 2^224: found and last at once.
    hmask = {32'h0, {224{1'b1}}};
    push_run(GENESIS, 256'd1 << 224, 32'h7C2BAC1D, 32'h7C2BAC1D);
    issue(GENESIS, 256'd1 << 224, 32'h7C2BAC1D, 32'h7C2BAC1D);
    wait_term("genesis");
    chk("genesis_exhausted_clear", exhausted, 1'b0);
    hmask = '1;

    // Unreachable target over 5..8.
    h2 = {GENESIS[639:320], 320'h1234_5678_9abc_def0_0fed_cba9_8765_4321_aaaa_5555_cccc_3333};
    s0 = n_starts;
    push_run(h2, '0, 32'd5, 32'd8);
    issue(h2, '0, 32'd5, 32'd8);
    wait_term("range5_8");
    chk("range5_8_starts", n_starts - s0, MID ? 5 : 8);

    // Range that wraps through zero.
    push_run(h2, '0, 32'hFFFF_FFFE, 32'h0000_0001);
    issue(h2, '0, 32'hFFFF_FFFE, 32'h0000_0001);
    wait_term("wrap");

    // digest equal to target is not a win; one above it is.
    d = cf(mk_b1(GENESIS, 32'd3), cf(GENESIS[639:128], IV));
    push_run(GENESIS, d, 32'd3, 32'd3);
    issue(GENESIS, d, 32'd3, 32'd3);
    wait_term("eq_target");
    push_run(GENESIS, d + 256'd1, 32'd3, 32'd3);
    issue(GENESIS, d + 256'd1, 32'd3, 32'd3);
    wait_term("above_target");

    // Silent core: error after exactly TMO cycles.
    mute = 1'b1;
    begin
      res_t r;
      r.f = 1'b0; r.e = 1'b0; r.er = 1'b1; r.chk = 1'b0; r.n = '0; r.h = '0;
      exp_res.push_back(r);
    end
    push_core(h2[639:128], IV);
    issue(h2, '0, 32'd1, 32'd4);
    chk("timeout_core_start", core_start, 1'b1);
    cyc = 0;
    hit = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      cyc++;
      if (error) begin
        hit = 1'b1;
        break;
      end
    end
    chk("timeout_seen", hit, 1'b1);
    chk("timeout_cycles", cyc, TMO);
    chk("timeout_busy", busy, 1'b0);
    @(negedge clk);
    mute = 1'b0;
    repeat (4) @(negedge clk);

    // Abort in WAIT1 on the same cycle as core_done.
    abort_arm = 1'b1;
    s0 = n_starts;
    push_core(h2[639:128], IV);
    push_core(mk_b1(h2, 32'd10), cf(h2[639:128], IV));
    issue(h2, '0, 32'd10, 32'd11);
    hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (abort) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("abort_fired", hit, 1'b1);
    @(negedge clk);
    abort_arm = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_found", found, 1'b0);
    chk("abort_exhausted", exhausted, 1'b0);
    chk("abort_error", error, 1'b0);
    repeat (20) @(negedge clk);
    chk("abort_idle_busy", busy, 1'b0);
    chk("abort_starts", n_starts - s0, 2);
    chk("abort_queue_drained", exp_core.size(), 0);

    // Three-nonce range: request count depends on the midstate build.
    s0 = n_starts;
    push_run(h2, '0, 32'd20, 32'd22);
    issue(h2, '0, 32'd20, 32'd22);
    wait_term("three_nonce");
    chk("three_nonce_starts", n_starts - s0, MID ? 4 : 6);

    // Reset in the middle of a run.
    push_core(h2[639:128], IV);
    push_core(mk_b1(h2, 32'd30), cf(h2[639:128], IV));
    issue(h2, '0, 32'd30, 32'd40);
    hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (exp_core.size() == 0) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("midrun_reached", hit, 1'b1);
    reset = 1'b1;
    #1;
    chk_zero("midrun_reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    chk_zero("midrun_after");

    // Normal operation after the mid-run reset.
    push_run(h2, '0, 32'd7, 32'd7);
    issue(h2, '0, 32'd7, 32'd7);
    wait_term("post_reset");

    repeat (3) @(negedge clk);
    chk("final_result_queue", exp_res.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
